clock_set_ctrl: RTL and testbench



---
 rtl/clock_set_ctrl_pkg.sv | 39 +++
 rtl/clock_set_ctrl_key_repeat.sv | 59 +++++
 rtl/clock_set_ctrl.sv | 153 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared encodings for the MM:SS clock mode/set controller.
package clock_set_ctrl_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned BLANK_W = 4;
    localparam int unsigned TO_W    = 6;

    // Controller states; 2'b11 is never entered on purpose.
    typedef enum logic [MODE_W-1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_MIN = 2'b01,
        MODE_SET_SEC = 2'b10
    } mode_e;

    // Digit positions in the blank mask.
    localparam logic [1:0] BLANK_SEC_ONES = 2'd0;
    localparam logic [1:0] BLANK_SEC_TENS = 2'd1;
    localparam logic [1:0] BLANK_MIN_ONES = 2'd2;
    localparam logic [1:0] BLANK_MIN_TENS = 2'd3;

    // Darken the field being set while the blink phase is 1.
    function automatic logic [BLANK_W-1:0] blank_mask(input mode_e mode, input logic phase);
        logic [BLANK_W-1:0] m;
        m = '0;
        case (mode)
            MODE_SET_MIN: begin
                m[BLANK_MIN_TENS] = phase;
                m[BLANK_MIN_ONES] = phase;
            end
            MODE_SET_SEC: begin
                m[BLANK_SEC_TENS] = phase;
                m[BLANK_SEC_ONES] = phase;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_key_repeat.sv
// Key press detector: one-cycle pulse on a rising level, with optional
// hold-to-repeat (first repeat REPEAT_DELAY cycles after the press, then
// every REPEAT_RATE cycles) when REPEAT_EN is set.
module key_repeat #(
    parameter bit          REPEAT_EN    = 1'b0,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic arm_en,
    input  logic cancel,
    output logic press_c,
    output logic rep_c
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic             key_q;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign press_c = key & ~key_q;
    assign rep_c   = REPEAT_EN & armed_q & key & (cnt_q == '0);

    // Arm on an accepted press; release or state change disarms at once.
    always_comb begin
        armed_d = armed_q;
        cnt_d   = cnt_q;
        if (cancel || !key) begin
            armed_d = 1'b0;
        end else if (press_c && arm_en && REPEAT_EN) begin
            armed_d = 1'b1;
        end
        if (press_c) begin
            cnt_d = CNT_W'(REPEAT_DELAY - 1);
        end else if (rep_c) begin
            cnt_d = CNT_W'(REPEAT_RATE - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Previous key sample, arm flag and repeat countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            key_q   <= key;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the MM:SS clock: RUN / SET_MIN / SET_SEC sequencing,
// seconds count gating, increment pulses, set-field blink and set timeout.
// Build option: CLOCK_SET_CTRL_AUTOREPEAT_EN enables hold-to-repeat on KEY_UP.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_DIV    = 12_500_000,
    parameter int unsigned TIMEOUT_SEC  = 10,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN1HZ,
    input  logic               KEY_MODE,
    input  logic               KEY_UP,
    output logic               CNT_EN,
    output logic               SEC_INC,
    output logic               MIN_INC,
    output logic [BLANK_W-1:0] BLANK,
    output logic [MODE_W-1:0]  MODE
);

    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

`ifdef CLOCK_SET_CTRL_AUTOREPEAT_EN
    localparam bit UP_REPEAT_EN = 1'b1;
`else
    localparam bit UP_REPEAT_EN = 1'b0;
`endif

    mode_e              state_q, state_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               phase_q, phase_d;
    logic               cnt_en_q, cnt_en_d;
    logic               sec_inc_q, sec_inc_d;
    logic               min_inc_q, min_inc_d;
    logic [BLANK_W-1:0] blank_q, blank_d;

    logic mode_press, mode_rep, up_press, up_rep;
    logic mode_evt, up_evt, in_set, up_ok, timeout;
    logic up_cancel;

    // KEY_MODE never repeats; KEY_UP repeats only when built with the option.
    key_repeat #(
        .REPEAT_EN    (1'b0),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_mode (
        .clk     (CLK),
        .rst     (RST),
        .key     (KEY_MODE),
        .arm_en  (1'b0),
        .cancel  (1'b0),
        .press_c (mode_press),
        .rep_c   (mode_rep)
    );

    key_repeat #(
        .REPEAT_EN    (UP_REPEAT_EN),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_up (
        .clk     (CLK),
        .rst     (RST),
        .key     (KEY_UP),
        .arm_en  (up_ok),
        .cancel  (up_cancel),
        .press_c (up_press),
        .rep_c   (up_rep)
    );

    assign mode_evt  = mode_press | mode_rep;
    assign up_evt    = up_press | up_rep;
    assign in_set    = (state_q == MODE_SET_MIN) || (state_q == MODE_SET_SEC);
    assign up_ok     = in_set & ~mode_evt;
    assign timeout   = in_set & EN1HZ & ~up_evt & (to_q == TO_W'(TIMEOUT_SEC - 1));
    assign up_cancel = (state_d != state_q);

    // Next state and next registered outputs; a MODE edge beats an UP edge,
    // and an UP edge beats the terminal timeout tick.
    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        blink_d   = blink_q;
        phase_d   = phase_q;
        cnt_en_d  = 1'b0;
        sec_inc_d = 1'b0;
        min_inc_d = 1'b0;
        blank_d   = '0;

        case (state_q)
            MODE_RUN:     if (mode_evt) state_d = MODE_SET_MIN;
            MODE_SET_MIN: if (mode_evt) state_d = MODE_SET_SEC;
                          else if (timeout) state_d = MODE_RUN;
            MODE_SET_SEC: if (mode_evt || timeout) state_d = MODE_RUN;
            default:      state_d = MODE_RUN;
        endcase

        min_inc_d = up_ok && up_evt && (state_q == MODE_SET_MIN);
        sec_inc_d = up_ok && up_evt && (state_q == MODE_SET_SEC);
        cnt_en_d  = EN1HZ && (state_q == MODE_RUN) && (state_d == MODE_RUN);

        if ((state_d != state_q) || mode_evt || up_evt) begin
            to_d = '0;
        end else if (in_set && EN1HZ) begin
            to_d = to_q + TO_W'(1);
        end

        if ((state_d != state_q) || min_inc_d || sec_inc_d || (state_d == MODE_RUN)) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + BLINK_W'(1);
        end

        blank_d = blank_mask(state_d, phase_d);
    end

    // State, counters and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= MODE_RUN;
            to_q      <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            cnt_en_q  <= 1'b0;
            sec_inc_q <= 1'b0;
            min_inc_q <= 1'b0;
            blank_q   <= '0;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            cnt_en_q  <= cnt_en_d;
            sec_inc_q <= sec_inc_d;
            min_inc_q <= min_inc_d;
            blank_q   <= blank_d;
        end
    end

    assign CNT_EN  = cnt_en_q;
    assign SEC_INC = sec_inc_q;
    assign MIN_INC = min_inc_q;
    assign BLANK   = blank_q;
    assign MODE    = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with small timing parameters.
module tb_clock_set_ctrl;

`ifdef CLOCK_SET_CTRL_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en1hz = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_up = 1'b0;
    logic       CNT_EN, SEC_INC, MIN_INC;
    logic [3:0] BLANK;
    logic [1:0] MODE;
    logic [8:0] outs;

    int checks = 0;
    int failures = 0;

    clock_set_ctrl #(
        .BLINK_DIV    (4),
        .TIMEOUT_SEC  (3),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (3)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .EN1HZ    (en1hz),
        .KEY_MODE (key_mode),
        .KEY_UP   (key_up),
        .CNT_EN   (CNT_EN),
        .SEC_INC  (SEC_INC),
        .MIN_INC  (MIN_INC),
        .BLANK    (BLANK),
        .MODE     (MODE)
    );

    always #5 clk = ~clk;

    assign outs = {CNT_EN, SEC_INC, MIN_INC, BLANK, MODE};

    typedef struct {
        logic       rst, en, km, ku;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [23];

    function automatic logic [8:0] ex(input logic c, input logic s, input logic n,
                                      input logic [3:0] b, input logic [1:0] m);
        return {c, s, n, b, m};
    endfunction

    function automatic vec_t mk(input logic r, input logic e, input logic km, input logic ku,
                                input logic [8:0] exp);
        vec_t v;
        v.rst = r; v.en = e; v.km = km; v.ku = ku; v.exp = exp;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en1hz = 1'b0; key_mode = 1'b0; key_up = 1'b0;
        step();
        check("reset", 16'(outs), 16'h0);
        rst = 1'b0;
    endtask

    task automatic enter_sec();
        key_mode = 1'b1; step();
        check("enter_min", 16'(MODE), 16'd1);
        key_mode = 1'b0; step();
        key_mode = 1'b1; step();
        check("enter_sec", 16'(MODE), 16'd2);
        key_mode = 1'b0;
    endtask

    task automatic sec_tick(input string name, input logic up, input logic [1:0] exp_mode,
                            input logic exp_sec);
        en1hz = 1'b1; key_up = up;
        step();
        check(name, 16'({CNT_EN, SEC_INC, MODE}), 16'({1'b0, exp_sec, exp_mode}));
        en1hz = 1'b0; key_up = 1'b0;
        step();
    endtask

    initial begin
        int         min_cnt;
        int         sec_cnt;
        logic       exp_sec;
        logic [3:0] exp_b;

        //            rst en km ku   cnt sec min blank    mode
        vecs[0]  = mk(1, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b00));
        vecs[1]  = mk(0, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b00));
        vecs[2]  = mk(0, 1, 0, 0, ex(1, 0, 0, 4'b0000, 2'b00));
        vecs[3]  = mk(0, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b00));
        vecs[4]  = mk(0, 0, 0, 1, ex(0, 0, 0, 4'b0000, 2'b00));
        vecs[5]  = mk(0, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b00));
        vecs[6]  = mk(0, 0, 1, 0, ex(0, 0, 0, 4'b0000, 2'b01));
        vecs[7]  = mk(0, 1, 1, 0, ex(0, 0, 0, 4'b0000, 2'b01));
        vecs[8]  = mk(0, 0, 0, 1, ex(0, 0, 1, 4'b0000, 2'b01));
        vecs[9]  = mk(0, 0, 0, 1, ex(0, 0, 0, 4'b0000, 2'b01));
        vecs[10] = mk(0, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b01));
        vecs[11] = mk(0, 0, 0, 1, ex(0, 0, 1, 4'b0000, 2'b01));
        vecs[12] = mk(0, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b01));
        vecs[13] = mk(0, 0, 1, 1, ex(0, 0, 0, 4'b0000, 2'b10));
        vecs[14] = mk(0, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b10));
        vecs[15] = mk(0, 0, 0, 1, ex(0, 1, 0, 4'b0000, 2'b10));
        vecs[16] = mk(0, 1, 0, 0, ex(0, 0, 0, 4'b0000, 2'b10));
        vecs[17] = mk(0, 0, 1, 0, ex(0, 0, 0, 4'b0000, 2'b00));
        vecs[18] = mk(0, 1, 0, 0, ex(1, 0, 0, 4'b0000, 2'b00));
        vecs[19] = mk(0, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b00));
        vecs[20] = mk(0, 1, 1, 0, ex(0, 0, 0, 4'b0000, 2'b01));
        vecs[21] = mk(1, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b00));
        vecs[22] = mk(0, 0, 0, 0, ex(0, 0, 0, 4'b0000, 2'b00));

        for (int i = 0; i < 23; i++) begin
            rst = vecs[i].rst; en1hz = vecs[i].en; key_mode = vecs[i].km; key_up = vecs[i].ku;
            step();
            check($sformatf("vec%0d", i), 16'(outs), 16'(vecs[i].exp));
        end
        rst = 1'b0; en1hz = 1'b0; key_mode = 1'b0; key_up = 1'b0;

        // RUN: tick every 10 cycles, CNT_EN one cycle after each
        for (int t = 0; t < 3; t++) begin
            for (int c = 0; c < 10; c++) begin
                en1hz = (c == 0);
                step();
                check("run_tick", 16'(outs), 16'((c == 0) ? ex(1, 0, 0, 4'b0000, 2'b00) : 9'h0));
            end
        end
        en1hz = 1'b0;

        // Blink in SET_MIN then SET_SEC, back to RUN
        do_reset();
        key_mode = 1'b1; step();
        check("blink_min_entry", 16'(outs), 16'(ex(0, 0, 0, 4'b0000, 2'b01)));
        key_mode = 1'b0;
        for (int j = 1; j < 16; j++) begin
            step();
            exp_b = (((j / 4) % 2) == 1) ? 4'b1100 : 4'b0000;
            check("blink_min", 16'(outs), 16'(ex(0, 0, 0, exp_b, 2'b01)));
        end
        key_mode = 1'b1; step();
        check("blink_sec_entry", 16'(outs), 16'(ex(0, 0, 0, 4'b0000, 2'b10)));
        key_mode = 1'b0;
        for (int j = 1; j < 12; j++) begin
            step();
            exp_b = (((j / 4) % 2) == 1) ? 4'b0011 : 4'b0000;
            check("blink_sec", 16'(outs), 16'(ex(0, 0, 0, exp_b, 2'b10)));
        end
        key_mode = 1'b1; step();
        check("blink_exit", 16'(outs), 16'(ex(0, 0, 0, 4'b0000, 2'b00)));
        key_mode = 1'b0;

        // Five separate UP presses in SET_MIN, first one while the field is dark
        do_reset();
        key_mode = 1'b1; step();
        key_mode = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            check("min_idle", 16'(outs), 16'(ex(0, 0, 0, (j == 4) ? 4'b1100 : 4'b0000, 2'b01)));
        end
        min_cnt = 0; sec_cnt = 0;
        for (int p = 0; p < 5; p++) begin
            key_up = 1'b1; step();
            min_cnt += int'(MIN_INC); sec_cnt += int'(SEC_INC);
            check("up_press", 16'(outs), 16'(ex(0, 0, 1, 4'b0000, 2'b01)));
            key_up = 1'b0; step();
            min_cnt += int'(MIN_INC); sec_cnt += int'(SEC_INC);
            check("up_release", 16'(outs), 16'(ex(0, 0, 0, 4'b0000, 2'b01)));
        end
        check("min_inc_count", 16'(min_cnt), 16'd5);
        check("sec_inc_count", 16'(sec_cnt), 16'd0);

        // Timeout after 3 ticks; the next tick in RUN passes through
        do_reset();
        enter_sec();
        sec_tick("to_a_t1", 1'b0, 2'b10, 1'b0);
        sec_tick("to_a_t2", 1'b0, 2'b10, 1'b0);
        sec_tick("to_a_t3", 1'b0, 2'b00, 1'b0);
        en1hz = 1'b1; step();
        check("tick_after_exit", 16'({CNT_EN, MODE}), 16'({1'b1, 2'b00}));
        en1hz = 1'b0;

        // Key edge on tick 2 restarts the count
        enter_sec();
        sec_tick("to_b_t1", 1'b0, 2'b10, 1'b0);
        sec_tick("to_b_t2", 1'b1, 2'b10, 1'b1);
        sec_tick("to_b_t3", 1'b0, 2'b10, 1'b0);
        sec_tick("to_b_t4", 1'b0, 2'b10, 1'b0);
        sec_tick("to_b_t5", 1'b0, 2'b00, 1'b0);

        // Key edge on the terminal tick wins
        enter_sec();
        sec_tick("to_c_t1", 1'b0, 2'b10, 1'b0);
        sec_tick("to_c_t2", 1'b0, 2'b10, 1'b0);
        sec_tick("to_c_t3", 1'b1, 2'b10, 1'b1);
        sec_tick("to_c_t4", 1'b0, 2'b10, 1'b0);
        sec_tick("to_c_t5", 1'b0, 2'b10, 1'b0);
        sec_tick("to_c_t6", 1'b0, 2'b00, 1'b0);

        // KEY_UP held 20 cycles in SET_SEC
        do_reset();
        enter_sec();
        key_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_sec = (i == 1) || (AUTOREP && (i == 9 || i == 12 || i == 15 || i == 18));
            check("hold_inc", 16'({SEC_INC, MIN_INC, CNT_EN, MODE}), 16'({exp_sec, 2'b00, 2'b10}));
            if (i == 5) check("hold_blank", 16'(BLANK), 16'(4'b0011));
        end
        key_up = 1'b0; step();
        check("hold_release", 16'({SEC_INC, MODE}), 16'({1'b0, 2'b10}));

        // Reset in the middle of a hold
        do_reset();
        enter_sec();
        key_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            rst = (i == 5);
            step();
            if (i == 5) begin
                check("hold_rst", 16'(outs), 16'h0);
            end else if (i < 5) begin
                check("hold_pre_rst", 16'({SEC_INC, MIN_INC, MODE}), 16'({(i == 1), 1'b0, 2'b10}));
            end else begin
                check("hold_post_rst", 16'({SEC_INC, MIN_INC, MODE}), 16'h0);
            end
        end
        rst = 1'b0; key_up = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
